// File: rtl/config_pkg.sv
// Shared definitions for the config_regs register bank:
// register map, CTRL bit positions, commit FSM states, lock magic word
// and the configuration-set struct used for both shadow and active copies.
package config_pkg;

  localparam int unsigned CFG_WORD_W = 32;
  localparam int unsigned CTRL_W     = 6;

  typedef enum logic [1:0] {
    REG_CTRL        = 2'd0,
    REG_DD_OFFSET   = 2'd1,
    REG_SAVE_OFFSET = 2'd2,
    REG_COMMIT      = 2'd3
  } reg_addr_e;

  localparam int unsigned CTRL_SDRAM_SWITCH       = 0;
  localparam int unsigned CTRL_SDRAM_WRITABLE     = 1;
  localparam int unsigned CTRL_DD_ENABLED         = 2;
  localparam int unsigned CTRL_SRAM_ENABLED       = 3;
  localparam int unsigned CTRL_FLASHRAM_ENABLED   = 4;
  localparam int unsigned CTRL_FLASHRAM_READ_MODE = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    APPLY   = 2'd2
  } commit_state_e;

  // "LOCK" in ASCII
  localparam logic [CFG_WORD_W-1:0] LOCK_MAGIC = 32'h4C4F_434B;

  // Offsets are held at full word width; bits above the configured offset
  // width are always written as zero so reads come back zero-extended.
  typedef struct packed {
    logic [CTRL_W-1:0]     ctrl;
    logic [CFG_WORD_W-1:0] dd_offset;
    logic [CFG_WORD_W-1:0] save_offset;
  } cfg_set_t;

  function automatic logic [CFG_WORD_W-1:0] offset_mask(input int unsigned width);
    if (width >= CFG_WORD_W) begin
      offset_mask = '1;
    end else begin
      offset_mask = (32'd1 << width) - 32'd1;
    end
  endfunction

endpackage

// File: rtl/config_regs_if.sv
// CPU-side register bus for config_regs: single-cycle req pulse,
// ack one cycle later with registered read data.
interface config_regs_if;
  import config_pkg::*;

  logic                  req;
  logic                  write;
  logic [1:0]            addr;
  logic [CFG_WORD_W-1:0] wdata;
  logic                  ack;
  logic [CFG_WORD_W-1:0] rdata;

  modport master (
    output req, write, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, write, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/config_regs.sv
// CPU-writable configuration bank feeding the PI address decoder.
// Writes land in a shadow copy; a COMMIT copies the shadow to the active
// outputs in one cycle, but only once the PI reports idle, so the PI never
// sees a half-updated configuration.
// Optional feature macro: CONFIG_WRITE_LOCK_EN (write-once lock via magic word).
module config_regs
  import config_pkg::*;
#(
  parameter int unsigned         OFFSET_W        = 26,
  parameter logic [OFFSET_W-1:0] DD_OFFSET_RST   = 26'h3BE_0000,
  parameter logic [OFFSET_W-1:0] SAVE_OFFSET_RST = 26'h3FE_0000,
  parameter logic [CTRL_W-1:0]   CTRL_RST        = 6'b111100
) (
  input  logic                clk,
  input  logic                reset_n,
  config_regs_if.slave        bus,
  input  logic                pi_idle,
  output logic                sdram_switch,
  output logic                sdram_writable,
  output logic                dd_enabled,
  output logic                sram_enabled,
  output logic                flashram_enabled,
  output logic                flashram_read_mode,
  output logic [OFFSET_W-1:0] dd_offset,
  output logic [OFFSET_W-1:0] save_offset,
  output logic                config_updated
);

  localparam logic [CFG_WORD_W-1:0] OFFSET_MASK = offset_mask(OFFSET_W);

  localparam cfg_set_t CFG_RST = '{
    ctrl:        CTRL_RST,
    dd_offset:   32'(DD_OFFSET_RST),
    save_offset: 32'(SAVE_OFFSET_RST)
  };

  cfg_set_t              shadow_q;
  cfg_set_t              shadow_next;
  cfg_set_t              active_q;
  commit_state_e         state_q;
  reg_addr_e             req_addr;
  logic                  lock_q;
  logic                  lock_req;
  logic                  wr_accept;
  logic                  commit_req;
  logic [CFG_WORD_W-1:0] read_data;

  assign req_addr  = reg_addr_e'(bus.addr);
  assign wr_accept = bus.req && bus.write && !lock_q;

`ifdef CONFIG_WRITE_LOCK_EN
  assign lock_req = wr_accept && (req_addr == REG_COMMIT) && (bus.wdata == LOCK_MAGIC);

  // Lock is sticky: once the magic word is written only reset clears it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q <= 1'b0;
    end else if (lock_req) begin
      lock_q <= 1'b1;
    end
  end
`else
  assign lock_req = 1'b0;
  assign lock_q   = 1'b0;
`endif

  // The magic word is a lock request, not a commit, when locking is built in
  assign commit_req = wr_accept && (req_addr == REG_COMMIT) && !lock_req;

  // Next shadow value; also forwarded into active so a write in the last
  // PENDING cycle is included in the apply that happens on the same edge
  always_comb begin
    shadow_next = shadow_q;
    if (wr_accept) begin
      case (req_addr)
        REG_CTRL:        shadow_next.ctrl        = bus.wdata[CTRL_W-1:0];
        REG_DD_OFFSET:   shadow_next.dd_offset   = bus.wdata & OFFSET_MASK;
        REG_SAVE_OFFSET: shadow_next.save_offset = bus.wdata & OFFSET_MASK;
        default:         ;
      endcase
    end
  end

  // Shadow register file written directly by the CPU
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= CFG_RST;
    end else begin
      shadow_q <= shadow_next;
    end
  end

  // Read mux: config registers report the shadow copy, address 3 reports status
  always_comb begin
    read_data = '0;
    case (req_addr)
      REG_CTRL:        read_data = {{(CFG_WORD_W-CTRL_W){1'b0}}, shadow_q.ctrl};
      REG_DD_OFFSET:   read_data = shadow_q.dd_offset;
      REG_SAVE_OFFSET: read_data = shadow_q.save_offset;
      REG_COMMIT:      read_data = {{(CFG_WORD_W-2){1'b0}}, lock_q, (state_q == PENDING)};
      default:         read_data = '0;
    endcase
  end

  // Fixed one-cycle bus response; rdata is zero whenever ack is low or on writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ack   <= bus.req;
      bus.rdata <= (bus.req && !bus.write) ? read_data : '0;
    end
  end

  // Commit FSM; the APPLY state is the cycle in which the new active values
  // and the config_updated pulse are visible
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      active_q       <= CFG_RST;
      config_updated <= 1'b0;
    end else begin
      config_updated <= 1'b0;
      case (state_q)
        IDLE: begin
          if (commit_req) begin
            state_q <= PENDING;
          end
        end
        PENDING: begin
          if (pi_idle) begin
            state_q        <= APPLY;
            active_q       <= shadow_next;
            config_updated <= 1'b1;
          end
        end
        APPLY: begin
          state_q <= commit_req ? PENDING : IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sdram_switch       = active_q.ctrl[CTRL_SDRAM_SWITCH];
  assign sdram_writable     = active_q.ctrl[CTRL_SDRAM_WRITABLE];
  assign dd_enabled         = active_q.ctrl[CTRL_DD_ENABLED];
  assign sram_enabled       = active_q.ctrl[CTRL_SRAM_ENABLED];
  assign flashram_enabled   = active_q.ctrl[CTRL_FLASHRAM_ENABLED];
  assign flashram_read_mode = active_q.ctrl[CTRL_FLASHRAM_READ_MODE];
  assign dd_offset          = active_q.dd_offset[OFFSET_W-1:0];
  assign save_offset        = active_q.save_offset[OFFSET_W-1:0];

  // Upper offset bits are always zero in the active copy and never leave the block
  if (OFFSET_W < CFG_WORD_W) begin : g_unused_hi
    logic unused_active_hi;
    assign unused_active_hi = ^{active_q.dd_offset[CFG_WORD_W-1:OFFSET_W],
                                active_q.save_offset[CFG_WORD_W-1:OFFSET_W]};
  end

endmodule

// File: tb/tb_config_regs.sv
// Self-checking bench for config_regs: a behavioural model of the commit
// rules is compared against the DUT every cycle, plus directed literal checks.
// Build with +define+CONFIG_WRITE_LOCK_EN to exercise the lock feature.
module tb_config_regs;

  logic        clk;
  logic        reset_n;
  logic        pi_idle;
  logic        sdram_switch, sdram_writable, dd_enabled, sram_enabled;
  logic        flashram_enabled, flashram_read_mode, config_updated;
  logic [25:0] dd_offset, save_offset;

  config_regs_if bus ();

  config_regs dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .bus                (bus),
    .pi_idle            (pi_idle),
    .sdram_switch       (sdram_switch),
    .sdram_writable     (sdram_writable),
    .dd_enabled         (dd_enabled),
    .sram_enabled       (sram_enabled),
    .flashram_enabled   (flashram_enabled),
    .flashram_read_mode (flashram_read_mode),
    .dd_offset          (dd_offset),
    .save_offset        (save_offset),
    .config_updated     (config_updated)
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  bit cmp_en       = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit w, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.req   = r;
    bus.write = w;
    bus.addr  = a;
    bus.wdata = d;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  function automatic logic [5:0] ctrl_out();
    return {flashram_read_mode, flashram_enabled, sram_enabled, dd_enabled, sdram_writable, sdram_switch};
  endfunction

  // ---------------- behavioural model ----------------
  logic [5:0]  sh_ctrl, act_ctrl;
  logic [25:0] sh_dd, sh_save, act_dd, act_save;
  bit          outstanding, just_applied, locked;
  bit          accept, is_commit, is_magic;
  logic        exp_ack, exp_pulse;
  logic [31:0] exp_rdata;

  // A commit request stays outstanding until a cycle with pi_idle; the copy
  // then happens at the end of that cycle using the newest shadow, and the
  // following cycle shows the pulse (a commit in that cycle re-arms).
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_ctrl = 6'b111100; sh_dd = 26'h3BE_0000; sh_save = 26'h3FE_0000;
      act_ctrl = sh_ctrl; act_dd = sh_dd; act_save = sh_save;
      outstanding = 0; just_applied = 0; locked = 0;
      exp_ack = 0; exp_rdata = 0; exp_pulse = 0;
    end else begin
      exp_ack   = bus.req;
      exp_rdata = 32'h0;
      if (bus.req && !bus.write) begin
        case (bus.addr)
          2'd0: exp_rdata = {26'h0, sh_ctrl};
          2'd1: exp_rdata = {6'h0, sh_dd};
          2'd2: exp_rdata = {6'h0, sh_save};
          default: exp_rdata = {30'h0, locked, outstanding};
        endcase
      end
      accept   = bus.req && bus.write && !locked;
      is_magic = 0;
`ifdef CONFIG_WRITE_LOCK_EN
      is_magic = accept && (bus.addr == 2'd3) && (bus.wdata == 32'h4C4F_434B);
`endif
      if (accept) begin
        case (bus.addr)
          2'd0: sh_ctrl = bus.wdata[5:0];
          2'd1: sh_dd   = bus.wdata[25:0];
          2'd2: sh_save = bus.wdata[25:0];
          default: ;
        endcase
      end
      is_commit = accept && (bus.addr == 2'd3) && !is_magic;
      if (is_magic) locked = 1;
      exp_pulse = 0;
      if (just_applied) begin
        just_applied = 0;
        outstanding  = is_commit;
      end else if (outstanding && pi_idle) begin
        act_ctrl = sh_ctrl; act_dd = sh_dd; act_save = sh_save;
        exp_pulse    = 1;
        just_applied = 1;
        outstanding  = 0;
      end else if (is_commit) begin
        outstanding = 1;
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("ack",            {31'h0, bus.ack},        {31'h0, exp_ack});
      checkOutput("rdata",          bus.rdata,               exp_rdata);
      checkOutput("ctrl",           {26'h0, ctrl_out()},     {26'h0, act_ctrl});
      checkOutput("dd_offset",      {6'h0, dd_offset},       {6'h0, act_dd});
      checkOutput("save_offset",    {6'h0, save_offset},     {6'h0, act_save});
      checkOutput("config_updated", {31'h0, config_updated}, {31'h0, exp_pulse});
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0; pi_idle = 1'b1;
    bus.req = 1'b0; bus.write = 1'b0; bus.addr = 2'd0; bus.wdata = 32'h0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    cmp_en = 1;

    // Reset values
    idleCycle();
    checkOutput("rst_dd",    {6'h0, dd_offset},   32'h03BE_0000);
    checkOutput("rst_save",  {6'h0, save_offset}, 32'h03FE_0000);
    checkOutput("rst_ctrl",  {26'h0, ctrl_out()}, 32'h3C);
    checkOutput("rst_pulse", {31'h0, config_updated}, 32'h0);

    // Basic commit with pi_idle high: visible two cycles after the COMMIT req
    applyStimulus(1, 1, 2'd0, 32'h1);
    applyStimulus(1, 1, 2'd1, 32'h0100_0000);
    applyStimulus(1, 1, 2'd3, 32'h0);
    idleCycle();
    checkOutput("c1_pre_sw",   {31'h0, sdram_switch}, 32'h0);
    checkOutput("c1_pre_dd",   {6'h0, dd_offset}, 32'h03BE_0000);
    checkOutput("c1_ack",      {31'h0, bus.ack}, 32'h1);
    idleCycle();
    checkOutput("c1_sw",       {31'h0, sdram_switch}, 32'h1);
    checkOutput("c1_dd",       {6'h0, dd_offset}, 32'h0100_0000);
    checkOutput("c1_pulse",    {31'h0, config_updated}, 32'h1);
    idleCycle();
    checkOutput("c1_pulse_end", {31'h0, config_updated}, 32'h0);

    // Commit held off by a busy PI, shadow write while pending
    pi_idle = 1'b0;
    applyStimulus(1, 1, 2'd3, 32'h0);
    repeat (10) idleCycle();
    checkOutput("c2_hold_save",  {6'h0, save_offset}, 32'h03FE_0000);
    checkOutput("c2_hold_pulse", {31'h0, config_updated}, 32'h0);
    applyStimulus(1, 0, 2'd3, 32'h0);
    idleCycle();
    checkOutput("c2_status", bus.rdata, 32'h1);
    applyStimulus(1, 1, 2'd2, 32'h200);
    idleCycle();
    pi_idle = 1'b1;
    idleCycle();
    checkOutput("c2_save",  {6'h0, save_offset}, 32'h200);
    checkOutput("c2_pulse", {31'h0, config_updated}, 32'h1);
    idleCycle();
    checkOutput("c2_pulse_end", {31'h0, config_updated}, 32'h0);

    // Write in last PENDING cycle is applied; write in APPLY cycle is not
    applyStimulus(1, 1, 2'd3, 32'h0);
    applyStimulus(1, 1, 2'd0, 32'h2A);
    applyStimulus(1, 1, 2'd0, 32'h15);
    checkOutput("c3_ctrl",  {26'h0, ctrl_out()}, 32'h2A);
    checkOutput("c3_pulse", {31'h0, config_updated}, 32'h1);
    idleCycle();
    checkOutput("c3_ctrl_hold", {26'h0, ctrl_out()}, 32'h2A);
    applyStimulus(1, 0, 2'd0, 32'h0);
    idleCycle();
    checkOutput("c3_rd_shadow", bus.rdata, 32'h15);

    // COMMIT during APPLY re-arms; pi_idle drop in APPLY does not undo the apply
    applyStimulus(1, 1, 2'd3, 32'h0);
    idleCycle();
    applyStimulus(1, 1, 2'd3, 32'h0);
    pi_idle = 1'b0;
    checkOutput("c4_ctrl",  {26'h0, ctrl_out()}, 32'h15);
    checkOutput("c4_pulse", {31'h0, config_updated}, 32'h1);
    idleCycle();
    checkOutput("c4_no_extra", {31'h0, config_updated}, 32'h0);
    applyStimulus(1, 0, 2'd3, 32'h0);
    idleCycle();
    checkOutput("c4_rearmed", bus.rdata, 32'h1);
    pi_idle = 1'b1;
    idleCycle();
    checkOutput("c4_pulse2", {31'h0, config_updated}, 32'h1);
    idleCycle();

    // Readback is truncated to the offset width
    applyStimulus(1, 1, 2'd1, 32'hFFFF_FFFF);
    applyStimulus(1, 0, 2'd1, 32'h0);
    checkOutput("rd_wr_rdata", bus.rdata, 32'h0);
    idleCycle();
    checkOutput("rd_ack",   {31'h0, bus.ack}, 32'h1);
    checkOutput("rd_rdata", bus.rdata, 32'h03FF_FFFF);
    idleCycle();
    checkOutput("rd_ack_end", {31'h0, bus.ack}, 32'h0);

    // Reset while a commit is pending
    pi_idle = 1'b0;
    applyStimulus(1, 1, 2'd3, 32'h0);
    idleCycle();
    idleCycle();
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rs_dd",   {6'h0, dd_offset},   32'h03BE_0000);
    checkOutput("rs_save", {6'h0, save_offset}, 32'h03FE_0000);
    checkOutput("rs_ctrl", {26'h0, ctrl_out()}, 32'h3C);
    idleCycle();
    idleCycle();
    #2 reset_n = 1'b1;
    pi_idle = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idleCycle();
      checkOutput("rs_no_pulse", {31'h0, config_updated}, 32'h0);
    end

    // Lock word, then CTRL=0 and COMMIT
    applyStimulus(1, 1, 2'd3, 32'h4C4F_434B);
    applyStimulus(1, 1, 2'd0, 32'h0);
    applyStimulus(1, 1, 2'd3, 32'h0);
    checkOutput("lk_ack_ctrl", {31'h0, bus.ack}, 32'h1);
    applyStimulus(1, 0, 2'd0, 32'h0);
    checkOutput("lk_ack_commit", {31'h0, bus.ack}, 32'h1);
    idleCycle();
`ifdef CONFIG_WRITE_LOCK_EN
    checkOutput("lk_ctrl_rd", bus.rdata, 32'h3C);
`else
    checkOutput("lk_ctrl_rd", bus.rdata, 32'h0);
`endif
    applyStimulus(1, 0, 2'd3, 32'h0);
    idleCycle();
`ifdef CONFIG_WRITE_LOCK_EN
    checkOutput("lk_status",   bus.rdata, 32'h2);
    checkOutput("lk_ctrl_out", {26'h0, ctrl_out()}, 32'h3C);
`else
    checkOutput("lk_status",   bus.rdata, 32'h0);
    checkOutput("lk_ctrl_out", {26'h0, ctrl_out()}, 32'h0);
`endif
    repeat (3) idleCycle();

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
